// File: rtl/fir_pkg.sv
// Shared definitions for the FIR run sequencer: state encoding used by the
// control FSM, the status register and the testbench.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG       = 3'd1,
        CLR       = 3'd2,
        MAC_START = 3'd3,
        MAC_WAIT  = 3'd4,
        NEXT      = 3'd5,
        DONE      = 3'd6
    } fsm_state_t;

endpackage

// File: rtl/fir_wdog_timer.sv
// Saturating watchdog for the MAC wait phase. 'expired' is raised in the
// WDOG_LIMIT-th consecutive enabled cycle after a clear, so the owner can
// leave on that same edge. The counter parks at WDOG_LIMIT and never wraps.
module fir_wdog_timer #(
    parameter int WDOG_W     = 10,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic clk_b,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LAST  = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up while enabled and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_q >= LAST);

endmodule

// File: rtl/fir_sterowanie_fsm.sv
// Sequencer for one FIR filtering run. Steps the sample address counter,
// launches the MAC engine once per sample and finishes when the counter
// reports the last sample. Abort and a MAC watchdog keep a hung datapath
// from stalling the block. Outputs are registered from the next state so
// each strobe lines up exactly with the state it belongs to.
module fir_sterowanie_fsm
    import fir_pkg::*;
#(
    parameter int WDOG_W     = 10,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic       clk_b,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mac_done,
    input  logic       licznik_full,
    output logic       FSM_zapisz_probki,
    output logic       FSM_reset_licznik,
    output logic       FSM_nowa_probka,
    output logic       FSM_mac_start,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [2:0] fsm_state
);

    fsm_state_t state_q, state_d;
    logic       timeout_err_q, timeout_err_d;
    logic       zapisz_q, zapisz_d;
    logic       reset_lic_q, reset_lic_d;
    logic       nowa_q, nowa_d;
    logic       mac_start_q, mac_start_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       wdog_expired;

    fir_wdog_timer #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk_b   (clk_b),
        .rst_n   (rst_n),
        .clr     (state_q == MAC_START),
        .en      (state_q == MAC_WAIT),
        .expired (wdog_expired)
    );

    // Next state and sticky timeout flag; abort overrides everything else,
    // and mac_done beats a watchdog expiry landing in the same cycle.
    always_comb begin
        state_d       = state_q;
        timeout_err_d = timeout_err_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = CFG;
                        timeout_err_d = 1'b0;
                    end
                end
                CFG:       state_d = CLR;
                CLR:       state_d = MAC_START;
                MAC_START: state_d = MAC_WAIT;
                MAC_WAIT: begin
                    if (mac_done) begin
                        state_d = licznik_full ? DONE : NEXT;
                    end else if (wdog_expired) begin
                        state_d       = IDLE;
                        timeout_err_d = 1'b1;
                    end
                end
                NEXT:      state_d = MAC_START;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Moore output decode, taken from the next state so the flops below
    // present each strobe in the same cycle as its state.
    always_comb begin
        zapisz_d    = (state_d == CFG);
        reset_lic_d = (state_d == CLR);
        mac_start_d = (state_d == MAC_START);
        nowa_d      = (state_d == NEXT);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, flag and output registers.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timeout_err_q <= 1'b0;
            zapisz_q      <= 1'b0;
            reset_lic_q   <= 1'b0;
            nowa_q        <= 1'b0;
            mac_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timeout_err_q <= timeout_err_d;
            zapisz_q      <= zapisz_d;
            reset_lic_q   <= reset_lic_d;
            nowa_q        <= nowa_d;
            mac_start_q   <= mac_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign FSM_zapisz_probki = zapisz_q;
    assign FSM_reset_licznik = reset_lic_q;
    assign FSM_nowa_probka   = nowa_q;
    assign FSM_mac_start     = mac_start_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign timeout_err       = timeout_err_q;
    assign fsm_state         = state_q;

endmodule
